filter_seq_ctrl: RTL and testbench

FILTER_SEQ_CTRL -- requirements
Module: filter_seq_ctrl

---
 rtl/filter_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_filter_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_seq_ctrl.sv
// Filter sequencing controller: stages the CIC filter resets out of reset,
// discards the settling samples, then buffers decimated samples in a small
// FIFO with a sticky overflow flag for the downstream consumer.
module filter_seq_ctrl #(
    parameter int DW      = 12,
    parameter int DISCARD = 2,
    parameter int DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          clr_ovf,
    output logic [2:0]    filt_rst_n,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_vld,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          ovf,
    output logic [1:0]    state
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [3:0]    DISC = 4'(DISCARD);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        WARMUP  = 2'd2,
        RUN     = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    relCnt_q, relCnt_d;
    logic [3:0]    warmCnt_q, warmCnt_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] outData_q, outData_d;
    logic          outValid_q, outValid_d;
    logic          ovf_q, ovf_d;
    logic          flush, full, pushReq, pushEff, popEff, setOvf, lastDiscard;

    assign lastDiscard = sample_vld && ((warmCnt_q + 4'd1) == DISC);
    assign flush       = !enable || (state_q == IDLE);
    assign full        = (count_q == FULL);
    assign pushReq     = enable && (state_q == RUN) && sample_vld;
    assign popEff      = outValid_q && out_ready;
    assign pushEff     = pushReq && (!full || popEff);
    assign setOvf      = pushReq && full && !popEff;

    // FSM state register together with the release-stage and warm-up counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            relCnt_q  <= 2'd0;
            warmCnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            relCnt_q  <= relCnt_d;
            warmCnt_q <= warmCnt_d;
        end
    end

    // Next-state logic; dropping enable anywhere outside IDLE aborts the run
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RELEASE;
            RELEASE: begin
                if (!enable)                state_d = IDLE;
                else if (relCnt_q == 2'd2)  state_d = (DISCARD == 0) ? RUN : WARMUP;
            end
            WARMUP: begin
                if (!enable)          state_d = IDLE;
                else if (lastDiscard) state_d = RUN;
            end
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Release stage advances once per RELEASE cycle; warm-up counts discarded strobes
    always_comb begin
        relCnt_d  = 2'd0;
        warmCnt_d = warmCnt_q;
        if ((state_q == RELEASE) && (state_d == RELEASE)) begin
            relCnt_d = relCnt_q + 2'd1;
        end
        if (flush) begin
            warmCnt_d = 4'd0;
        end else if ((state_q == WARMUP) && sample_vld) begin
            warmCnt_d = lastDiscard ? 4'd0 : (warmCnt_q + 4'd1);
        end
    end

    // Staged filter resets: integrator 1, then integrator 2, then decimator
    always_comb begin
        filt_rst_n = 3'b111;
        unique case (state_q)
            IDLE:    filt_rst_n = 3'b000;
            RELEASE: begin
                unique case (relCnt_q)
                    2'd0:    filt_rst_n = 3'b001;
                    2'd1:    filt_rst_n = 3'b011;
                    default: filt_rst_n = 3'b111;
                endcase
            end
            default: filt_rst_n = 3'b111;
        endcase
    end

    // FIFO storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (pushEff) mem_q[wrPtr_q] <= sample_in;
    end

    // FIFO pointer/count update and registered head word for the consumer
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;
        if (flush) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            outData_d  = '0;
            outValid_d = 1'b0;
        end else begin
            if (pushEff) wrPtr_d = wrPtr_q + AW'(1);
            if (popEff)  rdPtr_d = rdPtr_q + AW'(1);
            unique case ({pushEff, popEff})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            outValid_d = (count_d != '0);
            outData_d  = (pushEff && (wrPtr_q == rdPtr_d)) ? sample_in : mem_q[rdPtr_d];
        end
    end

    // Sticky overflow: a new overflow beats a same-cycle clear
    always_comb begin
        ovf_d = setOvf | (ovf_q & ~clr_ovf);
    end

    // FIFO and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign ovf       = ovf_q;
    assign state     = state_q;

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Testbench for filter_seq_ctrl: directed vector table, hand-written
// abort / asynchronous-reset sequences, then randomized traffic checked
// against a queue-based behavioural model.
module tb_filter_seq_ctrl;

    localparam int DW      = 12;
    localparam int DISCARD = 2;
    localparam int DEPTH   = 4;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          clr_ovf;
    logic [2:0]    filt_rst_n;
    logic [DW-1:0] sample_in;
    logic          sample_vld;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          ovf;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          en;
        logic          clr;
        logic          vld;
        logic [DW-1:0] data;
        logic          rdy;
        logic [1:0]    eState;
        logic [2:0]    eFilt;
        logic          eValid;
        logic [DW-1:0] eData;
        logic          eOvf;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: mode 0..3, release step 1..3, remaining discards, FIFO queue
    int            mMode;
    int            mRel;
    int            mLeft;
    logic [DW-1:0] mq[$];
    logic          mOvf;

    filter_seq_ctrl #(.DW(DW), .DISCARD(DISCARD), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clr_ovf    (clr_ovf),
        .filt_rst_n (filt_rst_n),
        .sample_in  (sample_in),
        .sample_vld (sample_vld),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf        (ovf),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(input logic en, input logic clr, input logic vld,
                                   input logic [DW-1:0] data, input logic rdy,
                                   input logic [1:0] eS, input logic [2:0] eF,
                                   input logic eV, input logic [DW-1:0] eD, input logic eO);
        vec_t v;
        v.en = en; v.clr = clr; v.vld = vld; v.data = data; v.rdy = rdy;
        v.eState = eS; v.eFilt = eF; v.eValid = eV; v.eData = eD; v.eOvf = eO;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the rising edge
    task automatic applyStimulus(input logic en, input logic clr, input logic vld,
                                 input logic [DW-1:0] data, input logic rdy);
        enable     = en;
        clr_ovf    = clr;
        sample_vld = vld;
        sample_in  = data;
        out_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] eS, input logic [2:0] eF,
                               input logic eV, input logic [DW-1:0] eD, input logic eO);
        check({tag, " state"}, 32'(state), 32'(eS));
        check({tag, " filt_rst_n"}, 32'(filt_rst_n), 32'(eF));
        check({tag, " out_valid"}, 32'(out_valid), 32'(eV));
        check({tag, " ovf"}, 32'(ovf), 32'(eO));
        if (eV) check({tag, " out_data"}, 32'(out_data), 32'(eD));
    endtask

    task automatic modelReset();
        mMode = 0;
        mRel  = 0;
        mLeft = 0;
        mq.delete();
        mOvf  = 1'b0;
    endtask

    // Advance the model by one clock given this cycle's inputs
    task automatic modelStep(input logic en, input logic clr, input logic vld,
                             input logic [DW-1:0] data, input logic rdy);
        bit pop;
        bit setOvf;
        pop    = (mq.size() > 0) && rdy;
        setOvf = 1'b0;
        if (mMode != 0 && !en) begin
            mMode = 0;
            mRel  = 0;
            mq.delete();
        end else begin
            case (mMode)
                0: if (en) begin mMode = 1; mRel = 1; end
                1: begin
                    if (mRel < 3) mRel++;
                    else begin
                        mLeft = DISCARD;
                        mMode = (DISCARD == 0) ? 3 : 2;
                    end
                end
                2: if (vld) begin
                    mLeft--;
                    if (mLeft == 0) mMode = 3;
                end
                default: begin
                    if (pop) mq.delete(0);
                    if (vld) begin
                        if (mq.size() < DEPTH) mq.push_back(data);
                        else setOvf = 1'b1;
                    end
                end
            endcase
        end
        mOvf = setOvf ? 1'b1 : (clr ? 1'b0 : mOvf);
    endtask

    function automatic logic [2:0] modelFilt();
        if (mMode == 0) return 3'b000;
        if (mMode == 1) return 3'((1 << mRel) - 1);
        return 3'b111;
    endfunction

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        clr_ovf    = 1'b0;
        sample_vld = 1'b0;
        sample_in  = '0;
        out_ready  = 1'b0;

        #2;
        check("reset state", 32'(state), 32'd0);
        check("reset filt_rst_n", 32'(filt_rst_n), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        #10;
        rst_n = 1'b1;

        // en clr vld data rdy | state filt valid data ovf
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 12'h055, 1'b0, 2'd0, 3'b000, 1'b0, 12'h000, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 2'd1, 3'b001, 1'b0, 12'h000, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h0AA, 1'b0, 2'd1, 3'b011, 1'b0, 12'h000, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 2'd1, 3'b111, 1'b0, 12'h000, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 2'd2, 3'b111, 1'b0, 12'h000, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h011, 1'b0, 2'd2, 3'b111, 1'b0, 12'h000, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h022, 1'b0, 2'd3, 3'b111, 1'b0, 12'h000, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h033, 1'b0, 2'd3, 3'b111, 1'b1, 12'h033, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 2'd3, 3'b111, 1'b0, 12'h000, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h101, 1'b0, 2'd3, 3'b111, 1'b1, 12'h101, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h102, 1'b0, 2'd3, 3'b111, 1'b1, 12'h101, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h103, 1'b0, 2'd3, 3'b111, 1'b1, 12'h101, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h104, 1'b0, 2'd3, 3'b111, 1'b1, 12'h101, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h105, 1'b0, 2'd3, 3'b111, 1'b1, 12'h101, 1'b1));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 2'd3, 3'b111, 1'b1, 12'h101, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h106, 1'b1, 2'd3, 3'b111, 1'b1, 12'h102, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 2'd3, 3'b111, 1'b1, 12'h103, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 2'd3, 3'b111, 1'b1, 12'h104, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 2'd3, 3'b111, 1'b1, 12'h106, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 2'd3, 3'b111, 1'b0, 12'h000, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 2'd3, 3'b111, 1'b0, 12'h000, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h107, 1'b0, 2'd3, 3'b111, 1'b1, 12'h107, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h108, 1'b1, 2'd3, 3'b111, 1'b1, 12'h108, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 2'd3, 3'b111, 1'b0, 12'h000, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h201, 1'b0, 2'd3, 3'b111, 1'b1, 12'h201, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h202, 1'b0, 2'd3, 3'b111, 1'b1, 12'h201, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h203, 1'b0, 2'd3, 3'b111, 1'b1, 12'h201, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 12'h204, 1'b0, 2'd3, 3'b111, 1'b1, 12'h201, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 12'h205, 1'b0, 2'd3, 3'b111, 1'b1, 12'h201, 1'b1));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 2'd3, 3'b111, 1'b1, 12'h201, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 2'd3, 3'b111, 1'b1, 12'h202, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].clr, vecs[i].vld, vecs[i].data, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].eState, vecs[i].eFilt,
                        vecs[i].eValid, vecs[i].eData, vecs[i].eOvf);
        end

        // Abort from RUN holding three entries, then a full restart
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        checkOutput("abort", 2'd0, 3'b000, 1'b0, 12'h000, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        checkOutput("restart1", 2'd1, 3'b001, 1'b0, 12'h000, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        checkOutput("restart2", 2'd1, 3'b011, 1'b0, 12'h000, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        checkOutput("restart3", 2'd1, 3'b111, 1'b0, 12'h000, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        checkOutput("restart4", 2'd2, 3'b111, 1'b0, 12'h000, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 12'h301, 1'b0);
        checkOutput("rewarm1", 2'd2, 3'b111, 1'b0, 12'h000, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 12'h302, 1'b0);
        checkOutput("rewarm2", 2'd3, 3'b111, 1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 12'(12'h303 + i), 1'b0);
            checkOutput($sformatf("refill%0d", i), 2'd3, 3'b111, 1'b1, 12'h303, (i == 4));
        end

        // Asynchronous reset pulsed between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async state", 32'(state), 32'd0);
        check("async filt_rst_n", 32'(filt_rst_n), 32'd0);
        check("async out_valid", 32'(out_valid), 32'd0);
        check("async out_data", 32'(out_data), 32'd0);
        check("async ovf", 32'(ovf), 32'd0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 12'h3AA, 1'b1);
        checkOutput("post-reset idle1", 2'd0, 3'b000, 1'b0, 12'h000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        checkOutput("post-reset idle2", 2'd0, 3'b000, 1'b0, 12'h000, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        checkOutput("post-reset start", 2'd1, 3'b001, 1'b0, 12'h000, 1'b0);

        // Randomized traffic against the behavioural model from a fresh reset
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        modelReset();
        for (int c = 0; c < 3000; c++) begin
            logic          en, clr, vld, rdy;
            logic [DW-1:0] data;
            en   = ($urandom_range(0, 39) != 0);
            clr  = ($urandom_range(0, 19) == 0);
            vld  = ($urandom_range(0, 9) < 6);
            rdy  = ($urandom_range(0, 9) < 4);
            data = DW'($urandom);
            modelStep(en, clr, vld, data, rdy);
            applyStimulus(en, clr, vld, data, rdy);
            checkOutput($sformatf("rand%0d", c), 2'(mMode), modelFilt(),
                        (mq.size() > 0), (mq.size() > 0) ? mq[0] : '0, mOvf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
